// File: rtl/mul_share_arb.sv
// Two-client round-robin arbiter sequencing one shared 2-stage unsigned multiplier.
// Each grant captures operands, multiplies, registers the result and pulses the owner's ack.
module mul_share_arb #(
  parameter int unsigned A_W = 3,
  parameter int unsigned B_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_0,
  input  logic [A_W-1:0]     a_0,
  input  logic [B_W-1:0]     b_0,
  input  logic               req_1,
  input  logic [A_W-1:0]     a_1,
  input  logic [B_W-1:0]     b_1,
  output logic               ack_0,
  output logic               ack_1,
  output logic [A_W+B_W-1:0] result,
  output logic               result_id,
  output logic               busy
);

  localparam int unsigned P_W = A_W + B_W;

  typedef enum logic [1:0] {StIdle, StMul, StRes, StAck} state_e;

  state_e         state_q, state_d;
  logic           last_id_q, last_id_d;
  logic           gnt_id_q, gnt_id_d;
  logic [A_W-1:0] op_a_q, op_a_d;
  logic [B_W-1:0] op_b_q, op_b_d;
  logic [P_W-1:0] prod_q, prod_d;
  logic [P_W-1:0] result_q, result_d;
  logic           result_id_q, result_id_d;
  logic [1:0]     ack_q, ack_d;
  logic           gnt;

  // Contention goes to the client that was not served last.
  always_comb begin
    gnt = req_1;
    if (req_0 && req_1) begin
      gnt = ~last_id_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_id_d   = last_id_q;
    gnt_id_d    = gnt_id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    prod_d      = prod_q;
    result_d    = result_q;
    result_id_d = result_id_q;
    ack_d       = 2'b00;
    case (state_q)
      StIdle: begin
        if (req_0 || req_1) begin
          state_d   = StMul;
          gnt_id_d  = gnt;
          last_id_d = gnt;
          op_a_d    = gnt ? a_1 : a_0;
          op_b_d    = gnt ? b_1 : b_0;
        end
      end
      StMul: begin
        prod_d  = P_W'(op_a_q) * P_W'(op_b_q);
        state_d = StRes;
      end
      StRes: begin
        result_d    = prod_q;
        result_id_d = gnt_id_q;
        ack_d       = gnt_id_q ? 2'b10 : 2'b01;
        state_d     = StAck;
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      last_id_q   <= 1'b1;
      gnt_id_q    <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      prod_q      <= '0;
      result_q    <= '0;
      result_id_q <= 1'b0;
      ack_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      last_id_q   <= last_id_d;
      gnt_id_q    <= gnt_id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      prod_q      <= prod_d;
      result_q    <= result_d;
      result_id_q <= result_id_d;
      ack_q       <= ack_d;
    end
  end

  assign ack_0     = ack_q[0];
  assign ack_1     = ack_q[1];
  assign result    = result_q;
  assign result_id = result_id_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb; expected results are queued at stimulus time and
// popped by a monitor whenever an ack pulse is observed.
module tb_mul_share_arb;

  localparam int unsigned A_W = 3;
  localparam int unsigned B_W = 4;
  localparam int unsigned P_W = A_W + B_W;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           req_0 = 1'b0;
  logic [A_W-1:0] a_0 = '0;
  logic [B_W-1:0] b_0 = '0;
  logic           req_1 = 1'b0;
  logic [A_W-1:0] a_1 = '0;
  logic [B_W-1:0] b_1 = '0;
  logic           ack_0, ack_1, result_id, busy;
  logic [P_W-1:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_ack0 = 0;
  int t_ack1 = 0;

  typedef struct packed {
    logic           id;
    logic [P_W-1:0] res;
  } exp_t;

  exp_t sb[$];

  mul_share_arb #(.A_W(A_W), .B_W(B_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_0     (req_0),
    .a_0       (a_0),
    .b_0       (b_0),
    .req_1     (req_1),
    .a_1       (a_1),
    .b_1       (b_1),
    .ack_0     (ack_0),
    .ack_1     (ack_1),
    .result    (result),
    .result_id (result_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void expect_res(input int id, input int a, input int b);
    exp_t e;
    e.id  = id[0];
    e.res = P_W'(a * b);
    sb.push_back(e);
  endfunction

  function automatic logic [A_W-1:0] op_a(input int j);
    return A_W'((j * 3 + 1) % 8);
  endfunction

  function automatic logic [B_W-1:0] op_b(input int j);
    return B_W'((j * 5 + 2) % 16);
  endfunction

  // Scoreboard monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (ack_0 || ack_1)) begin
      exp_t e;
      chk("ack_exclusive", {31'd0, ack_0 & ack_1}, 0);
      chk("sb_nonempty", {31'd0, sb.size() != 0}, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_result", {25'd0, result}, {25'd0, e.res});
        chk("sb_result_id", {31'd0, result_id}, {31'd0, e.id});
        chk("sb_ack_owner", {31'd0, ack_1}, {31'd0, e.id});
      end
    end
  end

  // Client model: drop each req on seeing its ack, until no request is pending.
  task automatic serve(input int budget);
    int n = 0;
    while ((req_0 || req_1) && n < budget) begin
      @(negedge clk);
      n++;
      if (ack_0) begin req_0 = 1'b0; t_ack0 = cyc; end
      if (ack_1) begin req_1 = 1'b0; t_ack1 = cyc; end
    end
    chk("serve_timeout", {31'd0, req_0 | req_1}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_0 = 1'b0;
    req_1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int  n0, n1;
    bit  rr0, rr1;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ack_0", {31'd0, ack_0}, 0);
    chk("rst_ack_1", {31'd0, ack_1}, 0);
    chk("rst_result", {25'd0, result}, 0);
    chk("rst_result_id", {31'd0, result_id}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request: 5*9, latency and busy window
    @(negedge clk);
    chk("t1_idle_busy", {31'd0, busy}, 0);
    expect_res(0, 5, 9);
    req_0 = 1'b1; a_0 = 3'd5; b_0 = 4'd9;
    @(negedge clk);
    chk("t1_c1_busy", {31'd0, busy}, 1);
    chk("t1_c1_ack", {31'd0, ack_0}, 0);
    @(negedge clk);
    chk("t1_c2_busy", {31'd0, busy}, 1);
    chk("t1_c2_ack", {31'd0, ack_0}, 0);
    @(negedge clk);
    chk("t1_c3_busy", {31'd0, busy}, 1);
    chk("t1_c3_ack_0", {31'd0, ack_0}, 1);
    chk("t1_c3_ack_1", {31'd0, ack_1}, 0);
    chk("t1_result", {25'd0, result}, 45);
    req_0 = 1'b0;
    @(negedge clk);
    chk("t1_c4_busy", {31'd0, busy}, 0);
    chk("t1_c4_ack", {31'd0, ack_0}, 0);

    // First contention after reset: client 0 first, client 1 four cycles later
    do_reset();
    expect_res(0, 2, 3);
    expect_res(1, 4, 5);
    req_0 = 1'b1; a_0 = 3'd2; b_0 = 4'd3;
    req_1 = 1'b1; a_1 = 3'd4; b_1 = 4'd5;
    serve(30);
    chk("t2_ack_spacing", t_ack1 - t_ack0, 4);

    // Sustained contention: 8 ops, strict alternation starting with client 0
    for (int j = 0; j < 8; j++) expect_res(j % 2, int'(op_a(j)), int'(op_b(j)));
    n0 = 0; n1 = 0; rr0 = 0; rr1 = 0;
    @(negedge clk);
    req_0 = 1'b1; a_0 = op_a(0); b_0 = op_b(0);
    req_1 = 1'b1; a_1 = op_a(1); b_1 = op_b(1);
    for (int k = 0; k < 100 && !(n0 == 4 && n1 == 4); k++) begin
      @(negedge clk);
      if (rr0) begin req_0 = 1'b1; a_0 = op_a(2 * n0); b_0 = op_b(2 * n0); rr0 = 0; end
      if (rr1) begin req_1 = 1'b1; a_1 = op_a(2 * n1 + 1); b_1 = op_b(2 * n1 + 1); rr1 = 0; end
      if (ack_0) begin n0++; req_0 = 1'b0; rr0 = (n0 < 4); end
      if (ack_1) begin n1++; req_1 = 1'b0; rr1 = (n1 < 4); end
    end
    chk("t3_acks_0", n0, 4);
    chk("t3_acks_1", n1, 4);

    // Width extremes
    @(negedge clk);
    expect_res(1, 7, 15);
    req_1 = 1'b1; a_1 = 3'd7; b_1 = 4'd15;
    serve(10);
    chk("t4_max_product", {25'd0, result}, 105);
    expect_res(0, 0, 15);
    req_0 = 1'b1; a_0 = 3'd0; b_0 = 4'd15;
    serve(10);
    chk("t4_zero_product", {25'd0, result}, 0);

    // Late request during MUL, operand change after grant
    @(negedge clk);
    expect_res(0, 6, 7);
    req_0 = 1'b1; a_0 = 3'd6; b_0 = 4'd7;
    @(negedge clk);
    chk("t5_mul_busy", {31'd0, busy}, 1);
    expect_res(1, 3, 5);
    req_1 = 1'b1; a_1 = 3'd3; b_1 = 4'd5;
    a_0 = 3'd2;
    serve(20);
    chk("t5_ack_spacing", t_ack1 - t_ack0, 4);

    // Reset during RES, request held across reset
    @(negedge clk);
    req_0 = 1'b1; a_0 = 3'd3; b_0 = 4'd3;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ack_0", {31'd0, ack_0}, 0);
    chk("t6_rst_ack_1", {31'd0, ack_1}, 0);
    chk("t6_rst_result", {25'd0, result}, 0);
    chk("t6_rst_result_id", {31'd0, result_id}, 0);
    chk("t6_rst_busy", {31'd0, busy}, 0);
    @(negedge clk);
    chk("t6_rst_hold_ack", {31'd0, ack_0}, 0);
    rst_n = 1'b1;
    expect_res(0, 3, 3);
    @(negedge clk);
    chk("t6_c1_ack", {31'd0, ack_0}, 0);
    @(negedge clk);
    chk("t6_c2_ack", {31'd0, ack_0}, 0);
    @(negedge clk);
    chk("t6_c3_ack", {31'd0, ack_0}, 1);
    chk("t6_result", {25'd0, result}, 9);
    req_0 = 1'b0;
    repeat (3) @(negedge clk);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
